regfile_mp: RTL and testbench

Parametrised multi-port register file for the CPU datapath. It replaces the fixed 32x32, 2-read/1-write file. It adds configurable width, depth and read-port count, a second write port with byte enables for load writeback, a hardwired zero register, a per-register pending scoreboard for hazard detection, and a sequenced clear operation. It sits between decode (reads, scoreboard set) and the ALU/load writeback stages (writes).

---
 rtl/regfile_mp.sv | 228 ++++++++++++++++++++++
 tb/tb_regfile_mp.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-port register file for the CPU datapath.
//            NUM_READ combinational read ports, a full-word ALU write port,
//            a byte-enabled load write port, optional hardwired zero
//            register, a per-register pending scoreboard and a sequenced
//            one-register-per-cycle clear.
// Options  : REGFILE_BYPASS_EN - when defined, a read port that addresses a
//            register being written in the same cycle returns the merged
//            write data, and its pending bit shows the post-write value.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_pending,
    input  logic                         wr0_en,
    input  logic [ADDR_W-1:0]            wr0_addr,
    input  logic [DATA_W-1:0]            wr0_data,
    input  logic                         wr1_en,
    input  logic [ADDR_W-1:0]            wr1_addr,
    input  logic [DATA_W-1:0]            wr1_data,
    input  logic [DATA_W/8-1:0]          wr1_be,
    input  logic                         sb_set_en,
    input  logic [ADDR_W-1:0]            sb_set_addr,
    input  logic                         clr_req,
    output logic                         clr_busy
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  sb_q;
    logic [DEPTH-1:0]  sb_d;
    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              w_busy;

    assign w_busy   = (state_q == ST_CLEAR);
    assign clr_busy = w_busy;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Byte merge shared by the write path and the bypass path: port 0 gives
    // the full word, port 1 overrides each byte whose enable is set.
    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] base,
        input logic              hit0,
        input logic [DATA_W-1:0] d0,
        input logic              hit1,
        input logic [NBYTES-1:0] be,
        input logic [DATA_W-1:0] d1
    );
        logic [DATA_W-1:0] w;
        w = hit0 ? d0 : base;
        for (int b = 0; b < NBYTES; b++) begin
            if (hit1 && be[b]) begin
                w[8*b +: 8] = d1[8*b +: 8];
            end
        end
        return w;
    endfunction

    // Address 0 is hardwired to zero only when ZERO_REG is set.
    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // ------------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------------
    // Next state: walk the counter through every register once, then idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state register; reset aborts any clear in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------------
    // Next contents: the clear owns the array while busy; otherwise apply
    // both write ports with the per-byte merge, skipping a hardwired r0.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (w_busy) begin
                if (cnt_q == ADDR_W'(i)) begin
                    regs_d[i] = '0;
                end
            end else if (!is_zero_addr(ADDR_W'(i))) begin
                regs_d[i] = merge_word(regs_q[i],
                                       wr0_en && (wr0_addr == ADDR_W'(i)), wr0_data,
                                       wr1_en && (wr1_addr == ADDR_W'(i)), wr1_be, wr1_data);
            end
        end
    end

    // Register array storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pending scoreboard
    // ------------------------------------------------------------------------
    // Next scoreboard: writes clear their target (even with no byte enables),
    // then an issue-time set is applied last so it wins on a collision.
    always_comb begin
        sb_d = sb_q;
        if (w_busy) begin
            sb_d[cnt_q] = 1'b0;
        end else begin
            if (wr0_en) begin
                sb_d[wr0_addr] = 1'b0;
            end
            if (wr1_en) begin
                sb_d[wr1_addr] = 1'b0;
            end
            if (sb_set_en && !is_zero_addr(sb_set_addr)) begin
                sb_d[sb_set_addr] = 1'b1;
            end
        end
    end

    // Scoreboard storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_pend;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

        // Combinational read with optional same-cycle write forwarding.
        always_comb begin
            w_data = regs_q[w_addr];
            w_pend = sb_q[w_addr];
`ifdef REGFILE_BYPASS_EN
            if (!w_busy && !is_zero_addr(w_addr) &&
                ((wr0_en && (wr0_addr == w_addr)) || (wr1_en && (wr1_addr == w_addr)))) begin
                w_data = merge_word(regs_q[w_addr],
                                    wr0_en && (wr0_addr == w_addr), wr0_data,
                                    wr1_en && (wr1_addr == w_addr), wr1_be, wr1_data);
                w_pend = sb_set_en && (sb_set_addr == w_addr);
            end
`endif
            if (is_zero_addr(w_addr)) begin
                w_data = '0;
                w_pend = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = w_data;
        assign rd_pending[k]               = w_pend;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Directed self-checking bench for regfile_mp (default build,
//            expectations adapt when REGFILE_BYPASS_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_READ = 2;
    localparam int DEPTH    = 1 << ADDR_W;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b1;
    logic [NUM_READ*ADDR_W-1:0] rd_addr = '0;
    logic [NUM_READ*DATA_W-1:0] rd_data;
    logic [NUM_READ-1:0]        rd_pending;
    logic                       wr0_en = 1'b0;
    logic [ADDR_W-1:0]          wr0_addr = '0;
    logic [DATA_W-1:0]          wr0_data = '0;
    logic                       wr1_en = 1'b0;
    logic [ADDR_W-1:0]          wr1_addr = '0;
    logic [DATA_W-1:0]          wr1_data = '0;
    logic [DATA_W/8-1:0]        wr1_be = '0;
    logic                       sb_set_en = 1'b0;
    logic [ADDR_W-1:0]          sb_set_addr = '0;
    logic                       clr_req = 1'b0;
    logic                       clr_busy;

    regfile_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_READ (NUM_READ),
        .ZERO_REG (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_pending  (rd_pending),
        .wr0_en      (wr0_en),
        .wr0_addr    (wr0_addr),
        .wr0_data    (wr0_data),
        .wr1_en      (wr1_en),
        .wr1_addr    (wr1_addr),
        .wr1_data    (wr1_data),
        .wr1_be      (wr1_be),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              pend;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rd_port = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic p);
        exp_t e;
        e.tag  = tag;
        e.addr = a;
        e.data = d;
        e.pend = p;
        exp_q.push_back(e);
    endtask

    // Pop every expected read, alternating read ports, and compare.
    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd_addr[rd_port*ADDR_W +: ADDR_W] = e.addr;
            #0.1;
            chk({e.tag, "_data"}, rd_data[rd_port*DATA_W +: DATA_W], e.data);
            chk({e.tag, "_pend"}, DATA_W'(rd_pending[rd_port]), DATA_W'(e.pend));
            rd_port = (rd_port + 1) % NUM_READ;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en    = 1'b0;
        wr1_en    = 1'b0;
        wr1_be    = '0;
        sb_set_en = 1'b0;
        clr_req   = 1'b0;
    endtask

    task automatic wr0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr0_en   = 1'b1;
        wr0_addr = a;
        wr0_data = d;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;

        // ---------------- reset asserted mid-cycle ----------------
        #3 reset_n = 1'b0;
        #0.1;
        chk("reset_busy", DATA_W'(clr_busy), '0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_reset_busy", DATA_W'(clr_busy), '0);
        for (int i = 0; i < DEPTH; i++) begin
            push("reset_rd", ADDR_W'(i), '0, 1'b0);
        end
        drain();

        // ---------------- dual write, byte merge ----------------
        wr0(5'd5, 32'hDEADBEEF);
        wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h11223344; wr1_be = 4'b0101;
        push("merge_same_cycle", 5'd5, BYP ? 32'hDE22BE44 : 32'h0, 1'b0);
        drain();
        tick();
        idle();
        push("merge_next", 5'd5, 32'hDE22BE44, 1'b0);
        drain();

        // ---------------- scoreboard set/clear ----------------
        sb_set_en = 1'b1; sb_set_addr = 5'd7;
        tick();
        idle();
        push("sb_set_r7", 5'd7, '0, 1'b1);
        drain();
        tick();
        tick();
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'hFFFFFFFF; wr1_be = 4'b0000;
        sb_set_en = 1'b1; sb_set_addr = 5'd7;
        tick();
        idle();
        push("sb_set_wins", 5'd7, '0, 1'b1);
        drain();
        wr0(5'd7, 32'h00000077);
        tick();
        idle();
        push("sb_wr0_clear", 5'd7, 32'h00000077, 1'b0);
        drain();
        sb_set_en = 1'b1; sb_set_addr = 5'd10;
        tick();
        idle();
        wr1_en = 1'b1; wr1_addr = 5'd10; wr1_data = 32'hCAFEF00D; wr1_be = 4'b0000;
        tick();
        idle();
        push("sb_wr1_be0_clear", 5'd10, '0, 1'b0);
        drain();

        // ---------------- zero register ----------------
        wr0(5'd0, 32'hFFFFFFFF);
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF; wr1_be = 4'b1111;
        sb_set_en = 1'b1; sb_set_addr = 5'd0;
        push("r0_same_cycle", 5'd0, '0, 1'b0);
        drain();
        tick();
        idle();
        push("r0_after", 5'd0, '0, 1'b0);
        drain();

        // ---------------- sequenced clear ----------------
        wr0(5'd3, 32'hA5A5A5A5);
        tick();
        wr0(5'd20, 32'h00000020);
        tick();
        wr0(5'd9, 32'h00000099);
        tick();
        idle();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr_busy_rise", DATA_W'(clr_busy), 32'd1);
        busy_cnt = 0;
        for (int c = 1; c <= 100 && clr_busy; c++) begin
            busy_cnt++;
            idle();
            if (c == 5) begin
                push("clr_mid_r3", 5'd3, '0, 1'b0);
                push("clr_mid_r20", 5'd20, 32'h00000020, 1'b0);
                drain();
            end
            if (c == 20) begin
                wr0(5'd9, 32'h00001234);
                sb_set_en = 1'b1; sb_set_addr = 5'd9;
                clr_req   = 1'b1;
            end
            tick();
        end
        idle();
        chk("clr_busy_cycles", DATA_W'(busy_cnt), 32'd32);
        push("clr_r3", 5'd3, '0, 1'b0);
        push("clr_r9", 5'd9, '0, 1'b0);
        push("clr_r20", 5'd20, '0, 1'b0);
        push("clr_r5", 5'd5, '0, 1'b0);
        drain();
        tick();
        chk("clr_no_restart", DATA_W'(clr_busy), '0);

        // ---------------- reset aborting a clear ----------------
        wr0(5'd25, 32'h25252525);
        tick();
        idle();
        push("pre_abort_r25", 5'd25, 32'h25252525, 1'b0);
        drain();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (9) tick();
        chk("abort_busy_c10", DATA_W'(clr_busy), 32'd1);
        #2 reset_n = 1'b0;
        #0.1;
        chk("abort_busy_now", DATA_W'(clr_busy), '0);
        push("abort_r25", 5'd25, '0, 1'b0);
        drain();
        tick();
        reset_n = 1'b1;
        tick();
        chk("abort_busy_after", DATA_W'(clr_busy), '0);

        // ---------------- same-cycle visibility ----------------
        wr0(5'd4, 32'h00001111);
        tick();
        wr0(5'd4, 32'h12345678);
        push("byp_same_cycle", 5'd4, BYP ? 32'h12345678 : 32'h00001111, 1'b0);
        drain();
        tick();
        idle();
        push("byp_next_cycle", 5'd4, 32'h12345678, 1'b0);
        drain();
        sb_set_en = 1'b1; sb_set_addr = 5'd11;
        tick();
        idle();
        wr0(5'd11, 32'h0000BBBB);
        push("byp_pend_same", 5'd11, BYP ? 32'h0000BBBB : 32'h0, !BYP);
        drain();
        tick();
        idle();
        push("byp_pend_next", 5'd11, 32'h0000BBBB, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
